// File: rtl/memory_responder_if.sv
// Request/response bus between the CPU address path (master) and the memory responder (slave).
interface memory_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        abort;

  modport master (
    output req, we, size, addr, wdata,
    input  rdata, ready, abort
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output rdata, ready, abort
  );
endinterface

// File: rtl/memory_responder.sv
// Memory-side endpoint: accepts one request, waits WAIT_STATES cycles, then answers with a
// single-cycle ready (with read data) or abort. Backs a little-endian word RAM.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  memory_responder_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            sel_we;
  logic [1:0]      sel_size;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_err;
  logic [IdxW-1:0] sel_idx;
  logic [31:0]     rd_word;
  logic [31:0]     rd_val;
  logic [31:0]     wr_word;
  logic            mem_we;

  // In IDLE the live inputs are decoded so a zero-wait response can be formed at the accept edge.
  always_comb begin
    if (state_q == StIdle) begin
      sel_we    = bus.we;
      sel_size  = bus.size;
      sel_addr  = bus.addr;
      sel_wdata = bus.wdata;
    end else begin
      sel_we    = we_q;
      sel_size  = size_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  always_comb begin
    sel_err = 1'b0;
    case (sel_size)
      2'b00:   sel_err = 1'b0;
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = |sel_addr[1:0];
      default: sel_err = 1'b1;
    endcase
    if (sel_addr[31:2] >= 30'(DEPTH_WORDS)) begin
      sel_err = 1'b1;
    end
  end

  assign sel_idx = sel_addr[IdxW+1:2];
  assign rd_word = mem[sel_idx];

  always_comb begin
    rd_val  = rd_word;
    wr_word = rd_word;
    case (sel_size)
      2'b00: begin
        rd_val                                  = {24'b0, rd_word[{sel_addr[1:0], 3'b000} +: 8]};
        wr_word[{sel_addr[1:0], 3'b000} +: 8]   = sel_wdata[7:0];
      end
      2'b01: begin
        rd_val                                  = {16'b0, rd_word[{sel_addr[1], 4'b0000} +: 16]};
        wr_word[{sel_addr[1], 4'b0000} +: 16]   = sel_wdata[15:0];
      end
      default: begin
        rd_val  = rd_word;
        wr_word = sel_wdata;
      end
    endcase
  end

  // The write lands at the edge that ends RESP; a reset on that edge suppresses it.
  assign mem_we = (state_q == StResp) && we_q && !sel_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    abort_d = 1'b0;
    rdata_d = 32'b0;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            ready_d = !sel_err;
            abort_d = sel_err;
            rdata_d = (sel_err || sel_we) ? 32'b0 : rd_val;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          ready_d = !sel_err;
          abort_d = sel_err;
          rdata_d = (sel_err || sel_we) ? 32'b0 : rd_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      ready_q <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[sel_idx] <= wr_word;
    end
  end

  assign bus.ready = ready_q;
  assign bus.abort = abort_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: two instances (2 and 0 wait states) checked against a
// scoreboard of expected responses, pushed at issue and popped when the response is due.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic [33:0] obs;
  int          cur_ws = 2;
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct packed {
    logic        rdy;
    logic        abt;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  memory_responder_if if0 ();
  memory_responder_if if1 ();

  assign if0.req   = req && !sel;
  assign if1.req   = req && sel;
  assign if0.we    = we;
  assign if1.we    = we;
  assign if0.size  = size;
  assign if1.size  = size;
  assign if0.addr  = addr;
  assign if1.addr  = addr;
  assign if0.wdata = wdata;
  assign if1.wdata = wdata;

  assign obs = sel ? {if1.ready, if1.abort, if1.rdata} : {if0.ready, if0.abort, if0.rdata};

  memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s (ws=%0d): observed rdy/abt/data=%b/%b/%h expected %b/%b/%h",
                tag, cur_ws, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s (ws=%0d): scoreboard empty when response due, observed %h expected none",
             tag, cur_ws, obs);
    end else begin
      e = sb.pop_front();
      check(tag, obs, e);
    end
  endtask

  // One transaction with the latency and pulse-width checks around it.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic err, input logic [31:0] exp_rd);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    e.rdy = !err; e.abt = err; e.data = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i <= cur_ws + 1; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 0) begin
        req = 1'b0; we = ~w; size = ~sz; addr = $urandom; wdata = $urandom;
      end
      if (i < cur_ws) check({tag, "/early"}, obs, 34'b0);
      else if (i == cur_ws) pop_check(tag);
      else check({tag, "/pulse"}, obs, 34'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_basic();
    txn("t1_wr", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("t1_rd", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    txn("t2_wrb", 1'b1, 2'b00, 32'h12, 32'hAABBCC55, 1'b0, 32'h0);
    txn("t2_rdw", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDE55BEEF);
    txn("t2_rdb13", 1'b0, 2'b00, 32'h13, 32'h0, 1'b0, 32'h000000DE);
    txn("t2_rdb10", 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 32'h000000EF);
    txn("t2_rdh", 1'b0, 2'b01, 32'h12, 32'h0, 1'b0, 32'h0000DE55);
    txn("t2_wr18", 1'b1, 2'b10, 32'h18, 32'h11223344, 1'b0, 32'h0);
    txn("t2_wrh", 1'b1, 2'b01, 32'h1A, 32'hFFFF9876, 1'b0, 32'h0);
    txn("t2_rd18", 1'b0, 2'b10, 32'h18, 32'h0, 1'b0, 32'h98763344);
    txn("t3_rdw11", 1'b0, 2'b10, 32'h11, 32'h0, 1'b1, 32'h0);
    txn("t3_rdh13", 1'b0, 2'b01, 32'h13, 32'h0, 1'b1, 32'h0);
    txn("t3_sz11", 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 32'h0);
    txn("t3_oob", 1'b0, 2'b10, 32'h1000, 32'h0, 1'b1, 32'h0);
    txn("t3_wr_oob", 1'b1, 2'b10, 32'h1010, 32'hFFFFFFFF, 1'b1, 32'h0);
    txn("t3_wr_hi", 1'b1, 2'b00, 32'h8000_0012, 32'h000000AA, 1'b1, 32'h0);
    txn("t3_wr_mis", 1'b1, 2'b10, 32'h11, 32'hFFFFFFFF, 1'b1, 32'h0);
    txn("t3_wrh_mis", 1'b1, 2'b01, 32'h13, 32'h0000FFFF, 1'b1, 32'h0);
    txn("t3_sz11_wr", 1'b1, 2'b11, 32'h10, 32'h0, 1'b1, 32'h0);
    txn("t3_unchanged", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDE55BEEF);
  endtask

  // Continuous req with an address that changes every cycle; only accept-edge addresses count.
  task automatic run_hold();
    int   p;
    int   k;
    exp_t e;
    p = cur_ws + 2;
    for (int i = 0; i < 8; i++) begin
      txn("t4_pre", 1'b1, 2'b10, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(32'h0101 * i), 1'b0,
          32'h0);
    end
    for (int c = 0; c < 3 * p; c++) begin
      k = (c * 3) % 8;
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40 + 32'(4 * k);
      if (c % p == 0) begin
        e.rdy = 1'b1; e.abt = 1'b0; e.data = 32'hA000_0000 + 32'(32'h0101 * k);
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (c % p == cur_ws) pop_check("t4_hold");
      else check("t4_hold/quiet", obs, 34'b0);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    @(posedge clk); #1;
    check("reset_dut0", {if0.ready, if0.abort, if0.rdata}, 34'b0);
    check("reset_dut1", {if1.ready, if1.abort, if1.rdata}, 34'b0);

    sel = 1'b0; cur_ws = 2;
    run_basic();
    run_hold();

    // Write killed by reset while in WAIT.
    txn("t5_prior", 1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    check("t5_accept", obs, 34'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_in_reset", obs, 34'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t5_quiet", obs, 34'b0);
    end
    txn("t5_rd", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

    sel = 1'b1; cur_ws = 0;
    run_basic();
    run_hold();

    n_total++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL sb_drain: observed %0d entries left expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
